// File: rtl/toy_pack.sv
// toy_pack: shared types and helpers for the instruction aligner
package toy_pack;
    typedef enum logic [1:0] {
        ALIGN_FULL = 2'd0,
        ALIGN_HALF = 2'd1,
        ALIGN_SKIP = 2'd2
    } align_state_e;

    function automatic logic is_rvc(logic [1:0] op);
        return op != 2'b11;
    endfunction
endpackage

// File: rtl/toy_fetch_align.sv
// toy_fetch_align: splits word-aligned fetch words into whole RVC/32-bit instructions with their PCs
module toy_fetch_align
    import toy_pack::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_en,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  word_vld,
    output logic                  word_rdy,
    input  logic [31:0]           word_data,
    output logic                  inst_vld,
    input  logic                  inst_rdy,
    output logic [31:0]           inst_pld,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_is_rvc
);
    align_state_e          state_q, state_d;
    logic [15:0]           res_q, res_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  low_rvc, res_rvc, blocked, fire, take;

    assign low_rvc = is_rvc(word_data[1:0]);
    assign res_rvc = is_rvc(res_q[1:0]);
    assign blocked = rst || flush_en;
    assign fire    = inst_vld && inst_rdy;
    assign take    = word_vld && word_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGN_FULL;
            res_q   <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            pc_q    <= pc_d;
        end
    end

    // Upper half of every accepted word becomes the residue; it only matters in ALIGN_HALF.
    always_comb begin
        state_d = flush_en ? (flush_pc[1] ? ALIGN_SKIP : ALIGN_FULL) :
                  state_q == ALIGN_SKIP ? (take ? ALIGN_HALF : ALIGN_SKIP) :
                  !fire ? state_q :
                  state_q == ALIGN_FULL ? (low_rvc ? ALIGN_HALF : ALIGN_FULL) :
                  (res_rvc ? ALIGN_FULL : ALIGN_HALF);
        res_d   = take ? word_data[31:16] : res_q;
        pc_d    = flush_en ? flush_pc :
                  fire ? pc_q + (inst_is_rvc ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4)) : pc_q;
    end

    always_comb begin
        inst_vld    = !blocked && (state_q == ALIGN_SKIP ? 1'b0 :
                                   (state_q == ALIGN_HALF && res_rvc) ? 1'b1 : word_vld);
        word_rdy    = !blocked && (state_q == ALIGN_SKIP ? 1'b1 :
                                   (state_q == ALIGN_HALF && res_rvc) ? 1'b0 : inst_rdy);
        inst_pld    = rst ? 32'h0 :
                      state_q == ALIGN_HALF ? (res_rvc ? {16'h0, res_q} : {word_data[15:0], res_q}) :
                      low_rvc ? {16'h0, word_data[15:0]} : word_data;
        inst_pc     = rst ? RESET_PC : pc_q;
        inst_is_rvc = !rst && is_rvc(inst_pld[1:0]);
    end
endmodule
